// File: rtl/ppu_mem_responder.sv
// VRAM/OAM storage for the PPU: pipelined PPU read port, mode-locked CPU port and OAM DMA engine.
// Port B of the memory is shared by the DMA and CPU; a DMA write in a cycle pre-empts any CPU access that cycle.
module ppu_mem_responder #(
  parameter int VRAM_BYTES = 8192,
  parameter int OAM_BYTES  = 160
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] ppu_addr_in,
  input  logic        ppu_req_in,
  output logic [7:0]  ppu_data_out,
  output logic        ppu_data_valid_out,
  input  logic [1:0]  ppu_mode_in,
  input  logic        lcd_enable_in,
  input  logic [15:0] cpu_addr_in,
  input  logic [7:0]  cpu_wdata_in,
  input  logic        cpu_we_in,
  input  logic        cpu_re_in,
  output logic [7:0]  cpu_rdata_out,
  output logic        cpu_rvalid_out,
  input  logic        dma_start_in,
  input  logic [7:0]  dma_page_in,
  output logic [15:0] dma_src_addr_out,
  output logic        dma_src_req_out,
  input  logic [7:0]  dma_src_data_in,
  input  logic        dma_src_valid_in,
  output logic        dma_busy_out
);

  // state     | meaning
  // DMA_IDLE  | no transfer in progress
  // DMA_REQ   | source read request driven for current idx
  // DMA_WAIT  | waiting for source data, then write OAM[idx]

  localparam int VA = $clog2(VRAM_BYTES);
  localparam int OA = $clog2(OAM_BYTES);
  localparam logic [16:0] VRAM_BASE = 17'h08000;
  localparam logic [16:0] VRAM_END  = VRAM_BASE + 17'(VRAM_BYTES);
  localparam logic [16:0] OAM_BASE  = 17'h0FE00;
  localparam logic [16:0] OAM_END   = OAM_BASE + 17'(OAM_BYTES);
  localparam logic [7:0]  DMA_LAST  = 8'(OAM_BYTES - 1);

  typedef enum logic [1:0] {SEL_VRAM, SEL_OAM, SEL_NONE} sel_t;
  typedef enum logic [1:0] {DMA_IDLE, DMA_REQ, DMA_WAIT} dma_state_t;

  function automatic sel_t decode(input logic [15:0] a);
    if ({1'b0, a} >= VRAM_BASE && {1'b0, a} < VRAM_END) return SEL_VRAM;
    if ({1'b0, a} >= OAM_BASE && {1'b0, a} < OAM_END)   return SEL_OAM;
    return SEL_NONE;
  endfunction

  logic [7:0] vram [VRAM_BYTES];
  logic [7:0] oam  [OAM_BYTES];

  dma_state_t dma_state;
  logic [7:0] dma_idx;
  logic [7:0] dma_page;
  logic       dma_wr;

  sel_t       ppu_sel, ppu_sel_q;
  logic       ppu_v_q;
  logic [7:0] ppu_vram_q, ppu_oam_q;

  sel_t       cpu_sel, cpu_sel_q;
  logic       cpu_locked, cpu_ok, cpu_rd, cpu_v_q, cpu_ok_q;
  logic       vram_lock, oam_lock, vram_we, oam_cpu_we;
  logic [7:0] cpu_vram_q, cpu_oam_q;

  assign ppu_sel    = decode(ppu_addr_in);
  assign cpu_sel    = decode(cpu_addr_in);
  assign vram_lock  = lcd_enable_in && (ppu_mode_in == 2'd3);
  assign oam_lock   = (lcd_enable_in && ppu_mode_in[1]) || dma_busy_out;
  assign dma_wr     = (dma_state == DMA_WAIT) && dma_src_valid_in && !dma_start_in;
  assign cpu_locked = (cpu_sel == SEL_VRAM && vram_lock) || (cpu_sel == SEL_OAM && oam_lock);
  assign cpu_ok     = (cpu_sel != SEL_NONE) && !cpu_locked && !dma_wr;
  assign cpu_rd     = cpu_re_in && !cpu_we_in;
  assign vram_we    = cpu_we_in && cpu_ok && (cpu_sel == SEL_VRAM);
  assign oam_cpu_we = cpu_we_in && cpu_ok && (cpu_sel == SEL_OAM);

  always_ff @(posedge clk_in) begin
    ppu_vram_q <= vram[ppu_addr_in[VA-1:0]];
    cpu_vram_q <= vram[cpu_addr_in[VA-1:0]];
    if (vram_we) vram[cpu_addr_in[VA-1:0]] <= cpu_wdata_in;
  end

  always_ff @(posedge clk_in) begin
    ppu_oam_q <= oam[ppu_addr_in[OA-1:0]];
    cpu_oam_q <= oam[cpu_addr_in[OA-1:0]];
    if (dma_wr)          oam[dma_idx[OA-1:0]]     <= dma_src_data_in;
    else if (oam_cpu_we) oam[cpu_addr_in[OA-1:0]] <= cpu_wdata_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ppu_v_q            <= 1'b0;
      ppu_sel_q          <= SEL_NONE;
      ppu_data_valid_out <= 1'b0;
      ppu_data_out       <= 8'h00;
      cpu_v_q            <= 1'b0;
      cpu_ok_q           <= 1'b0;
      cpu_sel_q          <= SEL_NONE;
      cpu_rvalid_out     <= 1'b0;
      cpu_rdata_out      <= 8'h00;
    end else begin
      ppu_v_q            <= ppu_req_in;
      ppu_sel_q          <= ppu_sel;
      ppu_data_valid_out <= ppu_v_q;
      case (ppu_sel_q)
        SEL_VRAM: ppu_data_out <= ppu_vram_q;
        SEL_OAM:  ppu_data_out <= ppu_oam_q;
        default:  ppu_data_out <= 8'hFF;
      endcase
      cpu_v_q        <= cpu_rd;
      cpu_ok_q       <= cpu_ok;
      cpu_sel_q      <= cpu_sel;
      cpu_rvalid_out <= cpu_v_q;
      if (!cpu_ok_q)                 cpu_rdata_out <= 8'hFF;
      else if (cpu_sel_q == SEL_OAM) cpu_rdata_out <= cpu_oam_q;
      else                           cpu_rdata_out <= cpu_vram_q;
    end
  end

  // A start pulse wins over everything, so a stale source valid in the restart cycle never writes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dma_state        <= DMA_IDLE;
      dma_idx          <= 8'h00;
      dma_page         <= 8'h00;
      dma_src_req_out  <= 1'b0;
      dma_src_addr_out <= 16'h0000;
      dma_busy_out     <= 1'b0;
    end else if (dma_start_in) begin
      dma_state        <= DMA_REQ;
      dma_idx          <= 8'h00;
      dma_page         <= (dma_page_in >= 8'hE0) ? dma_page_in - 8'h20 : dma_page_in;
      dma_src_req_out  <= 1'b1;
      dma_src_addr_out <= {((dma_page_in >= 8'hE0) ? dma_page_in - 8'h20 : dma_page_in), 8'h00};
      dma_busy_out     <= 1'b1;
    end else begin
      case (dma_state)
        DMA_REQ: begin
          dma_state       <= DMA_WAIT;
          dma_src_req_out <= 1'b0;
        end
        DMA_WAIT: begin
          if (dma_src_valid_in) begin
            if (dma_idx == DMA_LAST) begin
              dma_state    <= DMA_IDLE;
              dma_busy_out <= 1'b0;
            end else begin
              dma_state        <= DMA_REQ;
              dma_idx          <= dma_idx + 8'h01;
              dma_src_req_out  <= 1'b1;
              dma_src_addr_out <= {dma_page, dma_idx + 8'h01};
            end
          end
        end
        default: begin
          dma_src_req_out <= 1'b0;
          dma_busy_out    <= 1'b0;
        end
      endcase
    end
  end

endmodule
